// File: rtl/battleship_turn_engine.sv
// Turn-based Battleship engine for NUM_PLAYERS players: holds ship and shot maps,
// arbitrates shots in turn order, reports results and detects the winner.
module battleship_turn_engine #(
    parameter int unsigned GRID_W            = 10,
    parameter int unsigned GRID_H            = 10,
    parameter int unsigned NUM_PLAYERS       = 2,
    parameter int unsigned EXTRA_TURN_ON_HIT = 0
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic       place_we,
    input  logic [1:0] place_player,
    input  logic [3:0] place_x,
    input  logic [3:0] place_y,
    input  logic       place_done,
    input  logic       shot_valid,
    input  logic [3:0] shot_x,
    input  logic [3:0] shot_y,
    output logic       shot_ready,
    output logic       result_valid,
    output logic [1:0] result_code,
    output logic [1:0] result_target,
    output logic [3:0] result_x,
    output logic [3:0] result_y,
    output logic [1:0] cur_player,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int unsigned TOTAL = NUM_PLAYERS * CELLS;
    localparam int unsigned IDX_W = $clog2(TOTAL);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PLACE  = 3'd1;
    localparam logic [2:0] S_TURN   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;
    localparam logic [2:0] S_OVER   = 3'd5;

    localparam logic [1:0] CODE_MISS   = 2'b00;
    localparam logic [1:0] CODE_HIT    = 2'b01;
    localparam logic [1:0] CODE_REPEAT = 2'b10;
    localparam logic [1:0] CODE_RANGE  = 2'b11;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [TOTAL-1:0] ship_map;
    logic [TOTAL-1:0] shot_map;
    logic [7:0]       remaining [NUM_PLAYERS];

    logic [3:0]       shot_x_q;
    logic [3:0]       shot_y_q;
    logic [1:0]       shot_tgt_q;
    logic [1:0]       code_q;

    logic [3:0]       alive;
    logic [2:0]       alive_cnt;
    logic [1:0]       next_player;
    logic [1:0]       cand;
    logic             found;

    logic             place_ok;
    logic             place_new;
    logic [IDX_W-1:0] place_idx;
    logic             counts_ok;

    logic             shot_in_range;
    logic [IDX_W-1:0] shot_idx;
    logic [1:0]       shot_code;

    logic             shot_accept;
    logic             turn_passes;

    // Liveness and the next non-eliminated player after the current one.
    always_comb begin
        alive     = '0;
        alive_cnt = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            alive[p]  = (remaining[p] != 8'd0);
            alive_cnt = alive_cnt + 3'(alive[p]);
        end
        next_player = cur_player;
        found       = 1'b0;
        cand        = '0;
        for (int unsigned k = 1; k < NUM_PLAYERS; k++) begin
            cand = 2'((32'(cur_player) + k) % NUM_PLAYERS);
            if (!found && alive[cand]) begin
                next_player = cand;
                found       = 1'b1;
            end
        end
    end

    // Placement write qualification; place_done sees the count after this cycle's write.
    always_comb begin
        place_ok  = (state == S_PLACE) && place_we
                    && (3'(place_player) < 3'(NUM_PLAYERS))
                    && (5'(place_x) < 5'(GRID_W))
                    && (5'(place_y) < 5'(GRID_H));
        place_idx = IDX_W'(32'(place_player) * CELLS + 32'(place_y) * GRID_W + 32'(place_x));
        place_new = place_ok && !ship_map[place_idx];
        counts_ok = 1'b1;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            if ((remaining[p] == 8'd0) && !(place_new && (place_player == 2'(p)))) begin
                counts_ok = 1'b0;
            end
        end
    end

    // Shot classification against the latched target board.
    always_comb begin
        shot_in_range = (5'(shot_x_q) < 5'(GRID_W)) && (5'(shot_y_q) < 5'(GRID_H));
        shot_idx      = IDX_W'(32'(shot_tgt_q) * CELLS + 32'(shot_y_q) * GRID_W + 32'(shot_x_q));
        if (!shot_in_range) begin
            shot_code = CODE_RANGE;
        end else if (shot_map[shot_idx]) begin
            shot_code = CODE_REPEAT;
        end else if (ship_map[shot_idx]) begin
            shot_code = CODE_HIT;
        end else begin
            shot_code = CODE_MISS;
        end
    end

    assign shot_accept = (state == S_TURN) && shot_valid && shot_ready;
    assign turn_passes = (code_q == CODE_MISS)
                         || ((code_q == CODE_HIT) && (EXTRA_TURN_ON_HIT == 0));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_OVER: if (start) state_next = S_PLACE;
            S_PLACE:        if (place_done && counts_ok) state_next = S_TURN;
            S_TURN:         if (shot_accept) state_next = S_CHECK;
            S_CHECK:        state_next = S_REPORT;
            S_REPORT:       state_next = (alive_cnt == 3'd1) ? S_OVER : S_TURN;
            default:        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state         <= S_IDLE;
            ship_map      <= '0;
            shot_map      <= '0;
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) remaining[p] <= '0;
            shot_x_q      <= '0;
            shot_y_q      <= '0;
            shot_tgt_q    <= '0;
            code_q        <= '0;
            shot_ready    <= 1'b0;
            result_valid  <= 1'b0;
            result_code   <= '0;
            result_target <= '0;
            result_x      <= '0;
            result_y      <= '0;
            cur_player    <= '0;
            game_over     <= 1'b0;
            winner        <= '0;
        end else begin
            state        <= state_next;
            shot_ready   <= (state_next == S_TURN);
            result_valid <= (state == S_REPORT);
            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        ship_map   <= '0;
                        shot_map   <= '0;
                        for (int unsigned p = 0; p < NUM_PLAYERS; p++) remaining[p] <= '0;
                        cur_player <= '0;
                        game_over  <= 1'b0;
                    end
                end
                S_PLACE: begin
                    if (place_new) begin
                        ship_map[place_idx] <= 1'b1;
                        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                            if (place_player == 2'(p)) remaining[p] <= remaining[p] + 8'd1;
                        end
                    end
                end
                S_TURN: begin
                    if (shot_accept) begin
                        shot_x_q   <= shot_x;
                        shot_y_q   <= shot_y;
                        shot_tgt_q <= next_player;
                    end
                end
                S_CHECK: begin
                    code_q <= shot_code;
                    if (!shot_code[1]) shot_map[shot_idx] <= 1'b1;
                    if (shot_code == CODE_HIT) begin
                        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                            if (shot_tgt_q == 2'(p)) remaining[p] <= remaining[p] - 8'd1;
                        end
                    end
                end
                S_REPORT: begin
                    result_code   <= code_q;
                    result_target <= shot_tgt_q;
                    result_x      <= shot_x_q;
                    result_y      <= shot_y_q;
                    // The shooter is never eliminated by its own shot, so it is the survivor.
                    if (alive_cnt == 3'd1) begin
                        game_over <= 1'b1;
                        winner    <= cur_player;
                    end else if (turn_passes) begin
                        cur_player <= next_player;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_battleship_turn_engine.sv
// Directed bench: a default 2-player 10x10 engine and a 3-player 12-wide
// extra-turn engine share the stimulus; each scenario checks one of them.
module tb_battleship_turn_engine;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       place_we = 1'b0;
    logic [1:0] place_player = '0;
    logic [3:0] place_x = '0;
    logic [3:0] place_y = '0;
    logic       place_done = 1'b0;
    logic       shot_valid = 1'b0;
    logic [3:0] shot_x = '0;
    logic [3:0] shot_y = '0;

    logic       a_ready, a_rv, a_over, b_ready, b_rv, b_over;
    logic [1:0] a_code, a_tgt, a_cur, a_win, b_code, b_tgt, b_cur, b_win;
    logic [3:0] a_x, a_y, b_x, b_y;

    logic       s_ready, s_rv, s_over;
    logic [1:0] s_code, s_tgt, s_cur, s_win;
    logic [3:0] s_x, s_y;

    int checks = 0;
    int errors = 0;

    battleship_turn_engine dut_a (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start),
        .place_we(place_we), .place_player(place_player), .place_x(place_x),
        .place_y(place_y), .place_done(place_done), .shot_valid(shot_valid),
        .shot_x(shot_x), .shot_y(shot_y), .shot_ready(a_ready),
        .result_valid(a_rv), .result_code(a_code), .result_target(a_tgt),
        .result_x(a_x), .result_y(a_y), .cur_player(a_cur),
        .game_over(a_over), .winner(a_win)
    );

    battleship_turn_engine #(
        .GRID_W(12), .GRID_H(10), .NUM_PLAYERS(3), .EXTRA_TURN_ON_HIT(1)
    ) dut_b (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start),
        .place_we(place_we), .place_player(place_player), .place_x(place_x),
        .place_y(place_y), .place_done(place_done), .shot_valid(shot_valid),
        .shot_x(shot_x), .shot_y(shot_y), .shot_ready(b_ready),
        .result_valid(b_rv), .result_code(b_code), .result_target(b_tgt),
        .result_x(b_x), .result_y(b_y), .cur_player(b_cur),
        .game_over(b_over), .winner(b_win)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    task automatic sample(input bit on_b);
        if (on_b) begin
            s_ready = b_ready; s_rv = b_rv; s_code = b_code; s_tgt = b_tgt;
            s_x = b_x; s_y = b_y; s_cur = b_cur; s_over = b_over; s_win = b_win;
        end else begin
            s_ready = a_ready; s_rv = a_rv; s_code = a_code; s_tgt = a_tgt;
            s_x = a_x; s_y = a_y; s_cur = a_cur; s_over = a_over; s_win = a_win;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic place(input logic [1:0] p, input logic [3:0] x, input logic [3:0] y);
        place_we = 1'b1; place_player = p; place_x = x; place_y = y;
        tick();
        place_we = 1'b0;
    endtask

    task automatic end_place();
        place_done = 1'b1;
        tick();
        place_done = 1'b0;
    endtask

    task automatic check_reset_outputs(input bit on_b, input string tag);
        sample(on_b);
        check({tag, "_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_rv"},    32'(s_rv),    32'd0);
        check({tag, "_code"},  32'(s_code),  32'd0);
        check({tag, "_tgt"},   32'(s_tgt),   32'd0);
        check({tag, "_xy"},    32'({s_x, s_y}), 32'd0);
        check({tag, "_cur"},   32'(s_cur),   32'd0);
        check({tag, "_over"},  32'(s_over),  32'd0);
        check({tag, "_win"},   32'(s_win),   32'd0);
    endtask

    // Present one shot and verify the two-cycle result latency.
    task automatic shoot(input bit on_b, input string tag, input logic [3:0] x, input logic [3:0] y);
        int n = 0;
        sample(on_b);
        while (!s_ready && n < 20) begin
            tick();
            sample(on_b);
            n++;
        end
        check({tag, "_ready"}, 32'(s_ready), 32'd1);
        shot_x = x; shot_y = y; shot_valid = 1'b1;
        tick();
        shot_valid = 1'b0;
        sample(on_b);
        check({tag, "_ready_drop"}, 32'(s_ready), 32'd0);
        check({tag, "_rv_t0"}, 32'(s_rv), 32'd0);
        tick();
        sample(on_b);
        check({tag, "_rv_t1"}, 32'(s_rv), 32'd0);
        tick();
        sample(on_b);
        check({tag, "_rv_t2"}, 32'(s_rv), 32'd1);
    endtask

    task automatic expect_result(input string tag, input logic [1:0] code, input logic [1:0] tgt,
                                 input logic [3:0] x, input logic [3:0] y,
                                 input logic [1:0] cur, input logic over);
        check({tag, "_code"}, 32'(s_code), 32'(code));
        check({tag, "_tgt"},  32'(s_tgt),  32'(tgt));
        check({tag, "_xy"},   32'({s_x, s_y}), 32'({x, y}));
        check({tag, "_cur"},  32'(s_cur),  32'(cur));
        check({tag, "_over"}, 32'(s_over), 32'(over));
    endtask

    initial begin
        tick();
        do_reset();
        check_reset_outputs(1'b0, "rst_a");
        check_reset_outputs(1'b1, "rst_b");

        // Single hit on a one-cell board ends a 2-player game.
        pulse_start();
        place(2'd0, 4'd0, 4'd0);
        place(2'd1, 4'd3, 4'd3);
        end_place();
        sample(1'b0);
        check("t1_ready_after_place", 32'(s_ready), 32'd1);
        shoot(1'b0, "t1_shot", 4'd3, 4'd3);
        expect_result("t1", 2'b01, 2'd1, 4'd3, 4'd3, 2'd0, 1'b1);
        check("t1_winner", 32'(s_win), 32'd0);
        check("t1_ready_over", 32'(s_ready), 32'd0);
        tick();
        sample(1'b0);
        check("t1_rv_pulse", 32'(s_rv), 32'd0);
        check("t1_code_hold", 32'(s_code), 32'd1);
        check("t1_over_hold", 32'(s_over), 32'd1);

        // Miss, hit, repeat and out-of-range on the default engine.
        do_reset();
        pulse_start();
        place(2'd0, 4'd0, 4'd0);
        place(2'd0, 4'd9, 4'd9);
        place(2'd1, 4'd1, 4'd1);
        place(2'd1, 4'd2, 4'd2);
        end_place();
        pulse_start();
        sample(1'b0);
        check("t2_start_ignored_ready", 32'(s_ready), 32'd1);
        check("t2_start_ignored_cur", 32'(s_cur), 32'd0);
        shoot(1'b0, "t2_miss", 4'd5, 4'd5);
        expect_result("t2_miss", 2'b00, 2'd1, 4'd5, 4'd5, 2'd1, 1'b0);
        shoot(1'b0, "t2_hit", 4'd0, 4'd0);
        expect_result("t2_hit", 2'b01, 2'd0, 4'd0, 4'd0, 2'd0, 1'b0);
        shoot(1'b0, "t2_rep", 4'd5, 4'd5);
        expect_result("t2_rep", 2'b10, 2'd1, 4'd5, 4'd5, 2'd0, 1'b0);
        shoot(1'b0, "t2_oor", 4'd10, 4'd4);
        expect_result("t2_oor", 2'b11, 2'd1, 4'd10, 4'd4, 2'd0, 1'b0);

        // Three players, wider grid, extra turn on hit, placement gating.
        do_reset();
        pulse_start();
        place(2'd0, 4'd0, 4'd0);
        place(2'd1, 4'd2, 4'd2);
        end_place();
        tick();
        sample(1'b1);
        check("t3_done_ignored", 32'(s_ready), 32'd0);
        place(2'd2, 4'd7, 4'd7);
        place(2'd2, 4'd7, 4'd7);
        end_place();
        sample(1'b1);
        check("t3_done_honoured", 32'(s_ready), 32'd1);
        shoot(1'b1, "t3_oor", 4'd12, 4'd3);
        expect_result("t3_oor", 2'b11, 2'd1, 4'd12, 4'd3, 2'd0, 1'b0);
        shoot(1'b1, "t3_wide", 4'd10, 4'd4);
        expect_result("t3_wide", 2'b00, 2'd1, 4'd10, 4'd4, 2'd1, 1'b0);
        shoot(1'b1, "t3_p1", 4'd9, 4'd9);
        expect_result("t3_p1", 2'b00, 2'd2, 4'd9, 4'd9, 2'd2, 1'b0);
        shoot(1'b1, "t3_p2", 4'd5, 4'd5);
        expect_result("t3_p2", 2'b00, 2'd0, 4'd5, 4'd5, 2'd0, 1'b0);
        shoot(1'b1, "t3_elim1", 4'd2, 4'd2);
        expect_result("t3_elim1", 2'b01, 2'd1, 4'd2, 4'd2, 2'd0, 1'b0);
        shoot(1'b1, "t3_elim2", 4'd7, 4'd7);
        expect_result("t3_elim2", 2'b01, 2'd2, 4'd7, 4'd7, 2'd0, 1'b1);
        check("t3_winner", 32'(s_win), 32'd0);

        // Reset while a shot is in CHECK.
        do_reset();
        pulse_start();
        place(2'd0, 4'd0, 4'd0);
        place(2'd1, 4'd3, 4'd3);
        end_place();
        shot_x = 4'd3; shot_y = 4'd3; shot_valid = 1'b1;
        tick();
        shot_valid = 1'b0;
        do_reset();
        check_reset_outputs(1'b0, "t4_rst");
        shot_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            sample(1'b0);
            check("t4_no_ready", 32'(s_ready), 32'd0);
            check("t4_no_result", 32'(s_rv), 32'd0);
        end
        shot_valid = 1'b0;
        pulse_start();
        place(2'd0, 4'd0, 4'd0);
        place(2'd1, 4'd3, 4'd3);
        end_place();
        shoot(1'b0, "t4_after", 4'd4, 4'd4);
        expect_result("t4_after", 2'b00, 2'd1, 4'd4, 4'd4, 2'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/battleship_turn_engine.md
Name: battleship_turn_engine

Overview:
- Parametrised turn-based Battleship game engine for N players on a configurable grid.
- Holds each player's ship map and shot/tally map internally, and arbitrates shots in turn order.
- Reports each shot result on a one-cycle pulse that the display controller uses for drawing.
- Detects eliminations and the winner. It supersedes the fixed two-player 10x10 memory-based turn controller.

Parameters:
- GRID_W, 10, columns per board (2..16)
- GRID_H, 10, rows per board (2..16)
- NUM_PLAYERS, 2, number of players (2..4)
- EXTRA_TURN_ON_HIT, 0, mode select: 1 = shooter keeps the turn after a hit; 0 = turn always advances after a hit or a miss

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins ship placement from IDLE or OVER
- place_we  in  1  marks ship cell (place_x, place_y) for place_player; honoured only in PLACE
- place_player  in  2  player index for placement
- place_x  in  4  placement column
- place_y  in  4  placement row
- place_done  in  1  pulse; ends placement
- shot_valid  in  1  current player presents a shot
- shot_x  in  4  shot column
- shot_y  in  4  shot row
- shot_ready  out  1  engine can accept a shot
- result_valid  out  1  one-cycle pulse; result fields are valid
- result_code  out  2  00 miss, 01 hit, 10 repeat, 11 out-of-range
- result_target  out  2  board that was shot
- result_x  out  4  column of the shot
- result_y  out  4  row of the shot
- cur_player  out  2  player whose turn it is
- game_over  out  1  high in OVER
- winner  out  2  winning player index; valid while game_over is high

Behaviour:
- Reset (resetn=0 at a clock edge) is the only reset. Reset values:
  - state IDLE; all ship and shot bits 0
  - shot_ready=0, result_valid=0, result_code=0, result_target=0, result_x=0, result_y=0
  - cur_player=0, game_over=0, winner=0; remaining counters 0
- Reset mid-game aborts immediately to these values.
- States: IDLE, PLACE, TURN, CHECK, REPORT, OVER.
- IDLE: start -> PLACE.
- OVER: start -> PLACE. Entering PLACE clears all maps and counters, and sets cur_player=0.
- PLACE:
  - place_we with place_player < NUM_PLAYERS and an in-range coordinate sets the ship bit.
  - remaining[p] increments only if the bit was previously 0; duplicates are not counted.
  - Out-of-range place_we is ignored.
  - place_done is honoured only if every player has remaining >= 1; otherwise it is ignored and the engine stays in PLACE.
  - If place_we and place_done arrive in the same cycle, the write is applied first and the check uses the updated counts.
  - Honoured place_done -> TURN.
- TURN:
  - shot_ready=1.
  - Target = the next non-eliminated player after cur_player, cyclic modulo NUM_PLAYERS.
  - When shot_valid && shot_ready at edge T: latch the shot, shot_ready drops to 0, go to CHECK.
  - shot_ready stays low until the engine returns to TURN.
- CHECK (edge T+1): classify the shot.
  - 11 if x >= GRID_W or y >= GRID_H; no map change.
  - Otherwise 10 if the target's shot bit is already set; no map change.
  - Otherwise set the shot bit; 01 if the ship bit is set (decrement remaining[target]), else 00.
- REPORT (edge T+2): result_valid=1 for exactly one cycle; result fields hold their value until the next result.
- Turn update on leaving REPORT:
  - codes 10 and 11: cur_player unchanged; return to TURN.
  - code 00: cur_player advances to the next non-eliminated player.
  - code 01 with EXTRA_TURN_ON_HIT=1: cur_player unchanged.
  - code 01 with EXTRA_TURN_ON_HIT=0: cur_player advances.
- Elimination: a player with remaining=0 is eliminated and is skipped for both target and turn selection.
- If exactly one player remains non-eliminated after REPORT: go to OVER, winner=cur_player (the shooter), game_over=1, shot_ready=0.
- Shot latency: acceptance to result_valid is 2 cycles. Minimum period between accepted shots is 3 cycles.
- shot_valid outside TURN is ignored and is not queued.
- start during PLACE, TURN, CHECK or REPORT is ignored.
- Storage: NUM_PLAYERS*GRID_W*GRID_H ship bits plus the same number of shot bits, as flat register arrays. Remaining counters are 8 bits wide.

Test Plan:
- 2P, defaults. P0 ship at (0,0); P1 ship at (3,3); place_done. P0 shoots (3,3) -> 2 cycles later result_valid, code 01, target 1. Engine enters OVER with winner=0 and game_over=1.
- 2P. P1 ships at (1,1) and (2,2). P0 shoots (5,5) -> code 00, cur_player becomes 1. P1 shoots P0's (0,0): hit, turn advances to 0. P0 shoots (5,5) again -> code 10, cur_player stays 0.
- Shot (10,4) on the 10x10 grid -> code 11, no map change, cur_player unchanged. Same test with GRID_W=12 -> code 00.
- NUM_PLAYERS=3, EXTRA_TURN_ON_HIT=1. Eliminate P1 (single-cell ship) -> P0 keeps the turn, and its next target is P2. Eliminate P2 -> OVER, winner=0.
- place_done while P1 has 0 cells -> state stays PLACE. Duplicate place_we at the same cell -> remaining=1. Now the game requires only one hit to eliminate that player.
- Assert resetn=0 during CHECK -> next cycle: all outputs at reset values; a shot presented afterwards is ignored (shot_ready=0) until start and placement complete.
